decode_ctrl: RTL and testbench



---
 rtl/ctrl_pkg.sv | 78 +++++++
 rtl/scoreboard.sv | 47 ++++
 rtl/decode_ctrl.sv | 129 ++++++++++++
 tb/tb_decode_ctrl.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared types for the decode/control stage: opcode map, ALU op codes and
// the decoded control bundle, plus the opcode-to-control lookup.
package ctrl_pkg;

    typedef enum logic [3:0] {
        OP_ADD   = 4'd0,
        OP_SUB   = 4'd1,
        OP_AND   = 4'd2,
        OP_OR    = 4'd3,
        OP_XOR   = 4'd4,
        OP_ADDI  = 4'd5,
        OP_BEQ   = 4'd6,
        OP_PRINT = 4'd7,
        OP_NOP   = 4'd15
    } opcode_e;

    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_AND = 4'd2;
    localparam logic [3:0] ALU_OR  = 4'd3;
    localparam logic [3:0] ALU_XOR = 4'd4;

    typedef struct packed {
        logic [3:0] alu_op;
        logic       reg_write;
        logic       alu_src_imm;
        logic       branch;
        logic       print_req;
        logic       illegal;
    } ctrl_t;

    typedef struct packed {
        ctrl_t ctrl;
        logic  use_rs;
        logic  use_rt;
    } dec_t;

    localparam dec_t DEC_ILL = '{
        ctrl: '{alu_op: ALU_ADD, reg_write: 1'b0, alu_src_imm: 1'b0,
                branch: 1'b0, print_req: 1'b0, illegal: 1'b1},
        use_rs: 1'b0,
        use_rt: 1'b0
    };

    // Undefined opcodes decode as an illegal NOP: no sources, no strobes.
    function automatic dec_t decode_op(input logic [3:0] op);
        dec_t d;
        d = '0;
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
                d.ctrl.alu_op    = op;
                d.ctrl.reg_write = 1'b1;
                d.use_rs         = 1'b1;
                d.use_rt         = 1'b1;
            end
            OP_ADDI: begin
                d.ctrl.alu_op      = ALU_ADD;
                d.ctrl.alu_src_imm = 1'b1;
                d.ctrl.reg_write   = 1'b1;
                d.use_rs           = 1'b1;
            end
            OP_BEQ: begin
                d.ctrl.alu_op = ALU_SUB;
                d.ctrl.branch = 1'b1;
                d.use_rs      = 1'b1;
                d.use_rt      = 1'b1;
            end
            OP_PRINT: begin
                d.ctrl.print_req = 1'b1;
                d.use_rs         = 1'b1;
            end
            OP_NOP:  d = '0;
            default: d = DEC_ILL;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/scoreboard.sv
// Register scoreboard: one pending bit per register, set on commit, cleared on
// writeback, and a hazard lookup over up to three addresses.
module scoreboard #(
    parameter int RADDR_W = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    set_en_i,
    input  logic [RADDR_W-1:0]      set_addr_i,
    input  logic                    clr_en_i,
    input  logic [RADDR_W-1:0]      clr_addr_i,
    input  logic                    busy_en_i,
    input  logic [RADDR_W-1:0]      busy_addr_i,
    input  logic [2:0]              chk_en_i,
    input  logic [2:0][RADDR_W-1:0] chk_addr_i,
    output logic                    hazard_o
);

    localparam int NREGS = 2 ** RADDR_W;

    logic [NREGS-1:0] pending_q;
    logic [NREGS-1:0] pending_d;

    // Set is applied after clear so a same-register collision stays pending.
    always_comb begin
        pending_d = pending_q;
        if (clr_en_i) pending_d[clr_addr_i] = 1'b0;
        if (set_en_i) pending_d[set_addr_i] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) pending_q <= '0;
        else     pending_q <= pending_d;
    end

    // busy_* covers the bundle still sitting in the output register.
    always_comb begin
        hazard_o = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (chk_en_i[i] && (chk_addr_i[i] != '0) &&
                (pending_q[chk_addr_i[i]] ||
                 (busy_en_i && (busy_addr_i == chk_addr_i[i]))))
                hazard_o = 1'b1;
        end
    end

endmodule

// File: rtl/decode_ctrl.sv
// Registered decode stage: cracks an instruction, holds it behind a
// valid/ready handshake, stalls on scoreboard hazards and counts stall cycles.
module decode_ctrl
    import ctrl_pkg::*;
#(
    parameter int INSTR_W = 16,
    parameter int OP_W    = 4,
    parameter int RADDR_W = 4,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] instr,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [3:0]         alu_op,
    output logic               reg_write,
    output logic               alu_src_imm,
    output logic               branch,
    output logic               print_req,
    output logic               illegal,
    output logic [RADDR_W-1:0] rd,
    output logic [RADDR_W-1:0] rs,
    output logic [RADDR_W-1:0] rt,
    input  logic               wb_valid,
    input  logic [RADDR_W-1:0] wb_rd,
    input  logic               flush,
    output logic [CNT_W-1:0]   stall_cnt
);

    localparam int RD_HI = INSTR_W - OP_W - 1;

    logic [OP_W-1:0]    opcode;
    logic [RADDR_W-1:0] f_rd, f_rs, f_rt;
    dec_t               dec;
    logic               hazard, accept, commit;

    logic               out_valid_q, out_valid_d;
    ctrl_t              ctrl_q, ctrl_d;
    logic [RADDR_W-1:0] rd_q, rd_d, rs_q, rs_d, rt_q, rt_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    assign opcode = instr[INSTR_W-1 -: OP_W];
    assign f_rd   = instr[RD_HI -: RADDR_W];
    assign f_rs   = instr[RD_HI-RADDR_W -: RADDR_W];
    assign f_rt   = instr[RD_HI-2*RADDR_W -: RADDR_W];

    // Opcodes beyond the 4-bit map (wide OP_W) are illegal; r0 is never written.
    always_comb begin
        dec = decode_op(4'(opcode));
        if ((opcode >> 4) != '0) dec = DEC_ILL;
        if (f_rd == '0) dec.ctrl.reg_write = 1'b0;
    end

    scoreboard #(.RADDR_W(RADDR_W)) u_sb (
        .clk        (clk),
        .rst        (rst),
        .set_en_i   (commit),
        .set_addr_i (rd_q),
        .clr_en_i   (wb_valid),
        .clr_addr_i (wb_rd),
        .busy_en_i  (out_valid_q & ctrl_q.reg_write),
        .busy_addr_i(rd_q),
        .chk_en_i   ({dec.ctrl.reg_write, dec.use_rt, dec.use_rs}),
        .chk_addr_i ({f_rd, f_rt, f_rs}),
        .hazard_o   (hazard)
    );

    // Handshake: a transfer happens on a cycle where valid and ready are both
    // high; a flushed bundle is dropped without committing to the scoreboard.
    assign in_ready = (!out_valid_q | out_ready) & !hazard & !flush;
    assign accept   = in_valid & in_ready;
    assign commit   = out_valid_q & out_ready & !flush & ctrl_q.reg_write;

    always_comb begin
        out_valid_d = out_valid_q;
        ctrl_d      = ctrl_q;
        rd_d        = rd_q;
        rs_d        = rs_q;
        rt_d        = rt_q;
        if (accept) begin
            out_valid_d = 1'b1;
            ctrl_d      = dec.ctrl;
            rd_d        = f_rd;
            rs_d        = f_rs;
            rt_d        = f_rt;
        end else if (out_ready || flush) begin
            out_valid_d = 1'b0;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (in_valid && !in_ready && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            ctrl_q      <= '0;
            rd_q        <= '0;
            rs_q        <= '0;
            rt_q        <= '0;
            cnt_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            ctrl_q      <= ctrl_d;
            rd_q        <= rd_d;
            rs_q        <= rs_d;
            rt_q        <= rt_d;
            cnt_q       <= cnt_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign alu_op      = ctrl_q.alu_op;
    assign reg_write   = ctrl_q.reg_write;
    assign alu_src_imm = ctrl_q.alu_src_imm;
    assign branch      = ctrl_q.branch;
    assign print_req   = ctrl_q.print_req;
    assign illegal     = ctrl_q.illegal;
    assign rd          = rd_q;
    assign rs          = rs_q;
    assign rt          = rt_q;
    assign stall_cnt   = cnt_q;

endmodule

// File: tb/tb_decode_ctrl.sv
// Randomized and directed bench for decode_ctrl against a cycle-level
// reference model of the opcode table, scoreboard and handshake rules.
module tb_decode_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] instr = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [3:0]  alu_op;
    logic        reg_write, alu_src_imm, branch, print_req, illegal;
    logic [3:0]  rd, rs, rt;
    logic        wb_valid = 1'b0;
    logic [3:0]  wb_rd = '0;
    logic        flush = 1'b0;
    logic [3:0]  stall_cnt;

    decode_ctrl #(.INSTR_W(16), .OP_W(4), .RADDR_W(4), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .instr(instr), .out_valid(out_valid), .out_ready(out_ready),
        .alu_op(alu_op), .reg_write(reg_write), .alu_src_imm(alu_src_imm),
        .branch(branch), .print_req(print_req), .illegal(illegal),
        .rd(rd), .rs(rs), .rt(rt), .wb_valid(wb_valid), .wb_rd(wb_rd),
        .flush(flush), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    logic obs_ready;

    // Model state: exp_q holds the bundle sitting in the output register.
    logic [20:0] exp_q[$];
    bit   [15:0] m_pend;
    int          m_cnt;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Bundle layout {alu_op, rw, imm, br, pr, ill, rd, rs, rt}.
    task automatic mdec(input logic [15:0] ins, output logic [20:0] b,
                        output bit urs, output bit urt);
        logic [3:0] op, alu;
        bit rw, imm, br, pr, ill;
        op = ins[15:12];
        alu = 4'd0; rw = 0; imm = 0; br = 0; pr = 0; ill = 0; urs = 0; urt = 0;
        if (op <= 4)       begin alu = op; rw = 1; urs = 1; urt = 1; end
        else if (op == 5)  begin rw = 1; imm = 1; urs = 1; end
        else if (op == 6)  begin alu = 4'd1; br = 1; urs = 1; urt = 1; end
        else if (op == 7)  begin pr = 1; urs = 1; end
        else if (op != 15) ill = 1;
        if (ins[11:8] == 4'd0) rw = 0;
        b = {alu, rw, imm, br, pr, ill, ins[11:8], ins[7:4], ins[3:0]};
    endtask

    function automatic logic [20:0] dut_bundle();
        return {alu_op, reg_write, alu_src_imm, branch, print_req, illegal, rd, rs, rt};
    endfunction

    function automatic bit busy(input logic [3:0] a);
        logic [20:0] h;
        if (a == 4'd0) return 0;
        if (m_pend[a]) return 1;
        if (exp_q.size() != 0) begin
            h = exp_q[0];
            if (h[16] && h[11:8] == a) return 1;
        end
        return 0;
    endfunction

    task automatic step(input bit iv, input logic [15:0] ins, input bit ordy,
                        input bit wv, input logic [3:0] wr, input bit fl);
        logic [20:0] b, h;
        bit urs, urt, hz, exp_rdy, ov;
        @(negedge clk);
        in_valid = iv; instr = ins; out_ready = ordy; wb_valid = wv; wb_rd = wr; flush = fl;
        #1;
        mdec(ins, b, urs, urt);
        hz = (urs && busy(ins[7:4])) || (urt && busy(ins[3:0])) || (b[16] && busy(ins[11:8]));
        ov = exp_q.size() != 0;
        exp_rdy = (!ov || ordy) && !hz && !fl;
        obs_ready = in_ready;
        check("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
        check("out_valid", {31'd0, out_valid}, {31'd0, ov});
        check("stall_cnt", {28'd0, stall_cnt}, m_cnt);
        if (ov) check("bundle", {11'd0, dut_bundle()}, {11'd0, exp_q[0]});
        // Advance the model to the state after the coming clock edge.
        if (wv) m_pend[wr] = 1'b0;
        if (ov && ordy && !fl) begin
            h = exp_q[0];
            if (h[16]) m_pend[h[11:8]] = 1'b1;
        end
        if (iv && exp_rdy) begin
            exp_q.delete();
            exp_q.push_back(b);
        end else if (ordy || fl) begin
            exp_q.delete();
        end
        if (iv && !exp_rdy && m_cnt < 15) m_cnt++;
    endtask

    task automatic settle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        in_valid = 0; instr = '0; out_ready = 0; wb_valid = 0; wb_rd = '0; flush = 0;
        #2 rst = 1'b1;
        #1;
        check("rst_async_ov", {31'd0, out_valid}, 32'd0);
        check("rst_async_cnt", {28'd0, stall_cnt}, 32'd0);
        exp_q.delete();
        m_pend = '0;
        m_cnt = 0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_ready", {31'd0, in_ready}, 32'd1);
        check("rst_bundle", {11'd0, dut_bundle()}, 32'd0);
    endtask

    initial begin
        logic [15:0] ri;
        m_pend = '0;
        m_cnt = 0;
        repeat (2) @(negedge clk);
        do_reset();

        // ADD r1,r2,r3
        step(1, 16'h0123, 1, 0, 4'd0, 0);
        settle();
        check("add_ov", {31'd0, out_valid}, 32'd1);
        check("add_fields", {16'd0, alu_op, 3'd0, reg_write, rd, rs, rt}, 32'h0000_0123 | 32'h0000_1000);
        // SUB r4,r1,r5 stalls on r1 until after writeback
        step(1, 16'h1415, 1, 0, 4'd0, 0);
        check("sub_raw_held", {31'd0, obs_ready}, 32'd0);
        repeat (3) step(1, 16'h1415, 1, 0, 4'd0, 0);
        check("sub_pending", {31'd0, obs_ready}, 32'd0);
        settle();
        check("sub_stall_cnt", {28'd0, stall_cnt}, 32'd4);
        step(1, 16'h1415, 1, 1, 4'd1, 0);
        check("sub_wb_cycle", {31'd0, obs_ready}, 32'd0);
        step(1, 16'h1415, 1, 0, 4'd0, 0);
        check("sub_accept", {31'd0, obs_ready}, 32'd1);
        settle();
        check("sub_fields", {16'd0, alu_op, rd, rs, rt}, 32'h0000_1415);
        // ADDI r6,r0,7 then ADD r0,r1,r1
        step(1, 16'h5607, 1, 0, 4'd0, 0);
        settle();
        check("addi_flags", {28'd0, alu_src_imm, reg_write, alu_op[1:0]}, 32'hC);
        check("addi_rt", {28'd0, rt}, 32'd7);
        step(1, 16'h0011, 1, 0, 4'd0, 0);
        settle();
        check("add_r0_rw", {31'd0, reg_write}, 32'd0);
        step(1, 16'h9123, 1, 0, 4'd0, 0);
        settle();
        check("op9_strobes", {26'd0, illegal, reg_write, alu_src_imm, branch, print_req, out_valid}, 32'h21);
        step(1, 16'hF000, 1, 0, 4'd0, 0);
        settle();
        check("nop_strobes", {26'd0, illegal, reg_write, alu_src_imm, branch, print_req, out_valid}, 32'h01);
        step(0, 16'h0000, 1, 0, 4'd0, 0);

        // Flush kills a held writer without committing it
        do_reset();
        step(1, 16'h5607, 1, 0, 4'd0, 0);
        step(1, 16'h0161, 1, 0, 4'd0, 1);
        check("flush_ready", {31'd0, obs_ready}, 32'd0);
        settle();
        check("flush_ov", {31'd0, out_valid}, 32'd0);
        step(1, 16'h0161, 1, 0, 4'd0, 0);
        check("flush_no_commit", {31'd0, obs_ready}, 32'd1);

        // Commit and writeback of r2 in the same cycle: pending stays set
        do_reset();
        step(1, 16'h5200, 1, 0, 4'd0, 0);
        step(1, 16'hF000, 1, 1, 4'd2, 0);
        step(1, 16'h0120, 1, 0, 4'd0, 0);
        check("set_wins", {31'd0, obs_ready}, 32'd0);
        repeat (19) step(1, 16'h0120, 1, 0, 4'd0, 0);
        settle();
        check("stall_sat", {28'd0, stall_cnt}, 32'd15);

        // Random traffic with occasional mid-run resets
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 499) == 0) do_reset();
            ri = {4'($urandom_range(0, 15)), 4'($urandom_range(0, 7)),
                  4'($urandom_range(0, 7)), 4'($urandom_range(0, 7))};
            step($urandom_range(0, 3) != 0, ri, $urandom_range(0, 9) < 7,
                 $urandom_range(0, 9) < 3, 4'($urandom_range(0, 7)),
                 $urandom_range(0, 19) == 0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
